// File: rtl/bit_single_unit.sv
// bit_single_unit
//   Two-stage pipelined Zbs unit (bset / bclr / binv / bext). Stage 1 turns the
//   rs2 index into a one-hot mask. Stage 2 applies the mask to rs1 and drives the
//   out_* ports straight from registers. Both stages use a valid/ready handshake
//   with full backpressure, and a flush that kills everything still in flight.
//
//   Build option: define BIT_SINGLE_BEXT_EN to implement bext. When it is left
//   undefined, op 11 returns y = 0 with out_illegal = 1.
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     in_valid/in_ready   request handshake
//     in_op               00 bset, 01 bclr, 10 binv, 11 bext
//     in_a, in_b          rs1, rs2 (only in_b[IDX_W-1:0] used)
//     in_tag              opaque tag, echoed on out_tag
//     flush               synchronous kill of in-flight ops
//     out_valid/out_ready result handshake
//     out_y, out_tag      result and its tag
//     out_illegal         op not supported in this build
module bit_single_unit #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] OP_BSET = 2'b00;
  localparam logic [1:0] OP_BCLR = 2'b01;
  localparam logic [1:0] OP_BINV = 2'b10;
  localparam logic [1:0] OP_BEXT = 2'b11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
  logic [2:1]       vld_pipe;
  logic             s1_adv, s2_adv;

  logic [WIDTH-1:0] s1_a, s1_mask;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] s1_y, bext_y;
  logic             s1_ill;

  logic [WIDTH-1:0] s2_y;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_ill;

  // The index bits above IDX_W-1 are ignored by definition.
  logic unused_b_hi;
  assign unused_b_hi = ^in_b[WIDTH-1:IDX_W];

  assign s2_adv   = !vld_pipe[2] | out_ready;
  assign s1_adv   = !vld_pipe[1] | s2_adv;
  assign in_ready = s1_adv & !flush;

  // ---------------- Stage 1: capture operands, expand index ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_a        <= '0;
      s1_mask     <= '0;
      s1_op       <= '0;
      s1_tag      <= '0;
    end else if (flush) begin
      vld_pipe[1] <= 1'b0;
    end else if (s1_adv) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_mask <= ONE << in_b[IDX_W-1:0];
        s1_op   <= in_op;
        s1_tag  <= in_tag;
      end
    end
  end

  // ---------------- Mask application, one slice per bit --------------------
`ifdef BIT_SINGLE_BEXT_EN
  assign bext_y = {{(WIDTH-1){1'b0}}, |(s1_a & s1_mask)};
  assign s1_ill = 1'b0;
`else
  assign bext_y = '0;
  assign s1_ill = (s1_op == OP_BEXT);
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_comb begin
      s1_y[gi] = bext_y[gi];
      case (s1_op)
        OP_BSET: s1_y[gi] = s1_a[gi] |  s1_mask[gi];
        OP_BCLR: s1_y[gi] = s1_a[gi] & ~s1_mask[gi];
        OP_BINV: s1_y[gi] = s1_a[gi] ^  s1_mask[gi];
        default: s1_y[gi] = bext_y[gi];
      endcase
    end
  end

  // ---------------- Stage 2: result register, drives outputs ---------------
  // The payload only loads when a new op moves in. It therefore stays stable
  // while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      s2_y        <= '0;
      s2_tag      <= '0;
      s2_ill      <= 1'b0;
    end else if (flush) begin
      vld_pipe[2] <= 1'b0;
    end else if (s2_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        s2_y   <= s1_y;
        s2_tag <= s1_tag;
        s2_ill <= s1_ill;
      end
    end
  end

  assign out_valid   = vld_pipe[2];
  assign out_y       = s2_y;
  assign out_tag     = s2_tag;
  assign out_illegal = s2_ill;

endmodule
